// File: rtl/gps_bridge_pkg.sv
// Shared constants for the GPS sample bridge: sample bit positions, receive FSM
// states, byte width and the default receive FIFO depth.
package gps_bridge_pkg;

   localparam int BYTE_W             = 8;
   localparam int DEFAULT_FIFO_DEPTH = 8;

   localparam logic [1:0] I0_POS = 2'd3;
   localparam logic [1:0] I1_POS = 2'd2;
   localparam logic [1:0] Q0_POS = 2'd1;
   localparam logic [1:0] Q1_POS = 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RX    = 2'd1,
      ST_ABORT = 2'd2
   } rx_state_t;

   // Byte bit index for the n-th received bit: first nibble lands in [7:4].
   function automatic logic [2:0] bit_index(input logic [2:0] bit_cnt);
      logic [1:0] pos;
      case (bit_cnt[1:0])
         2'd0:    pos = I0_POS;
         2'd1:    pos = I1_POS;
         2'd2:    pos = Q0_POS;
         default: pos = Q1_POS;
      endcase
      return {~bit_cnt[2], pos};
   endfunction

endpackage

// File: rtl/gps_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with sticky overflow and a
// registered "at least two free entries" flow-control flag.
module gps_rx_fifo
   import gps_bridge_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic [BYTE_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              data_ready,
   output logic              push_accepted
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL      = (AW+1)'(DEPTH);
   localparam logic [AW:0] OCC_READY_MAX = (AW+1)'(DEPTH - 2);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       occupancy;
   logic [AW:0]       occ_next;
   logic              pop_ok;

   assign empty         = (occupancy == '0);
   assign full          = (occupancy == OCC_FULL);
   assign pop_ok        = pop && !empty;
   // When full, a same-cycle pop frees the slot the push needs.
   assign push_accepted = push && (!full || pop);
   assign dout          = mem[rd_ptr];

   always_comb begin
      occ_next = occupancy;
      if (push_accepted && !pop_ok)
         occ_next = occupancy + 1'b1;
      else if (!push_accepted && pop_ok)
         occ_next = occupancy - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         overflow   <= 1'b0;
         data_ready <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push_accepted) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop)
            overflow <= 1'b1;
         occupancy  <= occ_next;
         data_ready <= (occ_next <= OCC_READY_MAX);
      end
   end

endmodule

// File: rtl/gps_sample_rx.sv
// GPS I/Q sample receiver: deserialises I0,I1,Q0,Q1 bit groups from the MCU
// link into bytes and queues them in a FWFT FIFO.
module gps_sample_rx
   import gps_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int CNT_W      = 16
) (
   input  logic              MCU_CLK_25_000,
   input  logic              RESET_N,
   input  logic              MCU_SS,
   input  logic              MCU_SCK_EN,
   input  logic              MCU_MOSI,
   output logic              DATAREADY,
   input  logic              RD_EN,
   output logic [BYTE_W-1:0] DOUT,
   output logic              EMPTY,
   output logic              FULL,
   output logic              OVERFLOW,
   output logic              FRAME_ERR,
   output logic [CNT_W-1:0]  BYTE_COUNT
);

   rx_state_t         state;
   rx_state_t         state_next;
   logic              ss_q;
   logic              ss_fall;
   logic              sample;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-1:0] shift_reg;
   logic [BYTE_W-1:0] byte_asm;
   logic              push_q;
   logic [BYTE_W-1:0] push_byte;
   logic              push_accepted;
   logic [CNT_W-1:0]  byte_count;

   assign ss_fall    = ss_q && !MCU_SS;
   assign FRAME_ERR  = (state == ST_ABORT);
   assign BYTE_COUNT = byte_count;

   always_comb begin
      state_next = state;
      sample     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               state_next = ST_RX;
               sample     = MCU_SCK_EN;
            end
         end
         ST_RX: begin
            if (MCU_SS)
               state_next = (bit_cnt == 3'd0) ? ST_IDLE : ST_ABORT;
            else
               sample = MCU_SCK_EN;
         end
         ST_ABORT: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_asm                    = shift_reg;
      byte_asm[bit_index(bit_cnt)] = MCU_MOSI;
   end

   // Not reset, so a select held low through reset is never seen as a fall.
   always_ff @(posedge MCU_CLK_25_000) begin
      ss_q <= MCU_SS;
   end

   always_ff @(posedge MCU_CLK_25_000) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         push_q     <= 1'b0;
         push_byte  <= '0;
         byte_count <= '0;
      end else begin
         state  <= state_next;
         push_q <= sample && (bit_cnt == 3'd7);
         if (state == ST_ABORT) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else if (sample) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               push_byte <= byte_asm;
               shift_reg <= '0;
            end else begin
               shift_reg <= byte_asm;
            end
         end
         if (push_accepted)
            byte_count <= byte_count + 1'b1;
      end
   end

   gps_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk           (MCU_CLK_25_000),
      .rst_n         (RESET_N),
      .push          (push_q),
      .din           (push_byte),
      .pop           (RD_EN),
      .dout          (DOUT),
      .empty         (EMPTY),
      .full          (FULL),
      .overflow      (OVERFLOW),
      .data_ready    (DATAREADY),
      .push_accepted (push_accepted)
   );

endmodule

// File: tb/tb_gps_sample_rx.sv
// Randomised self-checking bench for gps_sample_rx against a queue-based
// behavioural model, plus directed cases with hand-computed expectations.
module tb_gps_sample_rx;

   localparam int DEPTH = 8;

   logic        MCU_CLK_25_000 = 1'b0;
   logic        RESET_N;
   logic        MCU_SS;
   logic        MCU_SCK_EN;
   logic        MCU_MOSI;
   logic        DATAREADY;
   logic        RD_EN;
   logic [7:0]  DOUT;
   logic        EMPTY;
   logic        FULL;
   logic        OVERFLOW;
   logic        FRAME_ERR;
   logic [15:0] BYTE_COUNT;

   int n_vectors     = 0;
   int n_miscompares = 0;
   int rd_pct        = 0;
   int ferr_seen     = 0;
   bit chk_en        = 1'b0;

   // behavioural model state
   bit         m_active   = 1'b0;
   bit         m_abort    = 1'b0;
   bit         m_ss_prev  = 1'b1;
   bit         m_pend     = 1'b0;
   logic [7:0] m_pend_byte = 8'h00;
   bit         m_bits[$];
   logic [7:0] m_fifo[$];
   bit         m_ovf      = 1'b0;
   int         m_cnt      = 0;
   bit         m_ready    = 1'b0;
   bit         m_ferr     = 1'b0;

   gps_sample_rx #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (16)
   ) dut (
      .MCU_CLK_25_000 (MCU_CLK_25_000),
      .RESET_N        (RESET_N),
      .MCU_SS         (MCU_SS),
      .MCU_SCK_EN     (MCU_SCK_EN),
      .MCU_MOSI       (MCU_MOSI),
      .DATAREADY      (DATAREADY),
      .RD_EN          (RD_EN),
      .DOUT           (DOUT),
      .EMPTY          (EMPTY),
      .FULL           (FULL),
      .OVERFLOW       (OVERFLOW),
      .FRAME_ERR      (FRAME_ERR),
      .BYTE_COUNT     (BYTE_COUNT)
   );

   always #20 MCU_CLK_25_000 = ~MCU_CLK_25_000;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic ss, input logic sck, input logic mosi);
      @(negedge MCU_CLK_25_000);
      MCU_SS     = ss;
      MCU_SCK_EN = sck;
      MCU_MOSI   = mosi;
      RD_EN      = (rd_pct != 0) && ($urandom_range(99) < rd_pct);
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b0, 1'b1, b[i]);
         repeat (gap) applyStimulus(1'b0, 1'b0, 1'($urandom_range(1)));
      end
   endtask

   task automatic takeBit();
      int val;
      if (MCU_SCK_EN) begin
         m_bits.push_back(MCU_MOSI);
         if (m_bits.size() == 8) begin
            val = 0;
            for (int i = 0; i < 8; i++)
               val = val * 2 + int'(m_bits[i]);
            m_pend      = 1'b1;
            m_pend_byte = val[7:0];
            m_bits.delete();
         end
      end
   endtask

   // Model: a completed byte reaches the FIFO one edge after its last bit.
   task automatic modelStep();
      bit pop_now;
      bit accept;
      if (!RESET_N) begin
         m_active = 1'b0;
         m_abort  = 1'b0;
         m_bits.delete();
         m_pend   = 1'b0;
         m_fifo.delete();
         m_ovf    = 1'b0;
         m_cnt    = 0;
         m_ready  = 1'b0;
         m_ferr   = 1'b0;
      end else begin
         pop_now = RD_EN && (m_fifo.size() > 0);
         accept  = m_pend && ((m_fifo.size() < DEPTH) || RD_EN);
         if (m_pend && !accept)
            m_ovf = 1'b1;
         if (pop_now)
            void'(m_fifo.pop_front());
         if (accept) begin
            m_fifo.push_back(m_pend_byte);
            m_cnt = (m_cnt + 1) % 65536;
         end
         m_ready = (m_fifo.size() <= DEPTH - 2);
         m_pend  = 1'b0;
         if (m_abort) begin
            m_abort = 1'b0;
         end else if (!m_active) begin
            if (m_ss_prev && !MCU_SS) begin
               m_active = 1'b1;
               takeBit();
            end
         end else if (MCU_SS) begin
            m_active = 1'b0;
            if (m_bits.size() != 0) begin
               m_abort = 1'b1;
               m_bits.delete();
            end
         end else begin
            takeBit();
         end
         m_ferr = m_abort;
      end
      m_ss_prev = MCU_SS;
   endtask

   initial forever begin
      @(posedge MCU_CLK_25_000);
      modelStep();
   end

   initial forever begin
      @(negedge MCU_CLK_25_000);
      if (FRAME_ERR === 1'b1)
         ferr_seen++;
      if (chk_en) begin
         checkOutput("EMPTY", EMPTY, m_fifo.size() == 0);
         checkOutput("FULL", FULL, m_fifo.size() == DEPTH);
         checkOutput("OVERFLOW", OVERFLOW, m_ovf);
         checkOutput("FRAME_ERR", FRAME_ERR, m_ferr);
         checkOutput("DATAREADY", DATAREADY, m_ready);
         checkOutput("BYTE_COUNT", BYTE_COUNT, m_cnt[15:0]);
         if (m_fifo.size() > 0)
            checkOutput("DOUT", DOUT, m_fifo[0]);
      end
   end

   task automatic endFrameAndDrain(input int cycles);
      applyStimulus(1'b1, 1'b0, 1'b0);
      rd_pct = 100;
      repeat (cycles) applyStimulus(1'b1, 1'b0, 1'b0);
      rd_pct = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int kind;
      int nb;
      RESET_N    = 1'b0;
      MCU_SS     = 1'b1;
      MCU_SCK_EN = 1'b0;
      MCU_MOSI   = 1'b0;
      RD_EN      = 1'b0;

      repeat (3) @(negedge MCU_CLK_25_000);
      chk_en = 1'b1;
      checkOutput("rst_EMPTY", EMPTY, 1);
      checkOutput("rst_FULL", FULL, 0);
      checkOutput("rst_OVERFLOW", OVERFLOW, 0);
      checkOutput("rst_FRAME_ERR", FRAME_ERR, 0);
      checkOutput("rst_DATAREADY", DATAREADY, 0);
      checkOutput("rst_DOUT", DOUT, 8'h00);
      checkOutput("rst_BYTE_COUNT", BYTE_COUNT, 0);
      RESET_N = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("post_rst_DATAREADY", DATAREADY, 1);

      // single byte 1,0,1,1,0,1,0,0
      sendByte(8'hB4, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("b4_EMPTY_latency", EMPTY, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("model_head_B4", m_fifo[0], 8'hB4);
      checkOutput("b4_DOUT", DOUT, 8'hB4);
      checkOutput("b4_EMPTY", EMPTY, 0);
      checkOutput("b4_BYTE_COUNT", BYTE_COUNT, 1);
      endFrameAndDrain(1);
      checkOutput("b4_drained_EMPTY", EMPTY, 1);

      // gapped frame, two bytes
      ferr_seen = 0;
      sendByte(8'h3C, 1);
      sendByte(8'hA5, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("gap_DOUT0", DOUT, 8'h3C);
      applyStimulus(1'b1, 1'b0, 1'b0);
      rd_pct = 100;
      applyStimulus(1'b1, 1'b0, 1'b0);
      rd_pct = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("gap_DOUT1", DOUT, 8'hA5);
      checkOutput("gap_BYTE_COUNT", BYTE_COUNT, 3);
      endFrameAndDrain(1);
      checkOutput("gap_FRAME_ERR_count", ferr_seen, 0);

      // aborted frame after 5 bits, then a good frame
      ferr_seen = 0;
      repeat (5) applyStimulus(1'b0, 1'b1, 1'($urandom_range(1)));
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("abort_FRAME_ERR_count", ferr_seen, 1);
      checkOutput("abort_BYTE_COUNT", BYTE_COUNT, 3);
      checkOutput("abort_EMPTY", EMPTY, 1);
      sendByte(8'h5A, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("after_abort_DOUT", DOUT, 8'h5A);
      checkOutput("after_abort_BYTE_COUNT", BYTE_COUNT, 4);
      endFrameAndDrain(1);

      // fill to full, overflow, then push with simultaneous read
      for (int i = 0; i < DEPTH; i++) begin
         sendByte(8'($urandom), 0);
         applyStimulus(1'b0, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("fill_DATAREADY", DATAREADY, (i + 1) <= DEPTH - 2);
         checkOutput("fill_FULL", FULL, i == DEPTH - 1);
      end
      checkOutput("full_BYTE_COUNT", BYTE_COUNT, 12);
      sendByte(8'h99, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("ovf_OVERFLOW", OVERFLOW, 1);
      checkOutput("ovf_BYTE_COUNT", BYTE_COUNT, 12);
      checkOutput("ovf_FULL", FULL, 1);
      sendByte(8'h77, 0);
      rd_pct = 100;
      applyStimulus(1'b0, 1'b0, 1'b0);
      rd_pct = 0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pushpop_FULL", FULL, 1);
      checkOutput("pushpop_BYTE_COUNT", BYTE_COUNT, 13);
      endFrameAndDrain(DEPTH + 2);

      // reset in the middle of a frame
      ferr_seen = 0;
      repeat (3) applyStimulus(1'b0, 1'b1, 1'($urandom_range(1)));
      applyStimulus(1'b0, 1'b0, 1'b0);
      RESET_N = 1'b0;
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
      RESET_N = 1'b1;
      sendByte(8'hFF, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("midrst_EMPTY", EMPTY, 1);
      checkOutput("midrst_BYTE_COUNT", BYTE_COUNT, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      sendByte(8'hC3, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("midrst_DOUT", DOUT, 8'hC3);
      checkOutput("midrst_BYTE_COUNT_after", BYTE_COUNT, 1);
      checkOutput("midrst_FRAME_ERR_count", ferr_seen, 0);
      endFrameAndDrain(1);

      // randomised traffic
      repeat (200) begin
         rd_pct = $urandom_range(0, 60);
         kind   = $urandom_range(9);
         if (kind < 7) begin
            nb = $urandom_range(1, 3);
            repeat (nb) sendByte(8'($urandom), $urandom_range(0, 2));
            repeat ($urandom_range(1, 2)) applyStimulus(1'b1, 1'b0, 1'b0);
         end else if (kind < 9) begin
            repeat ($urandom_range(1, 7)) applyStimulus(1'b0, 1'b1, 1'($urandom_range(1)));
            repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
         end else begin
            repeat (3) applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
         end
      end
      rd_pct = 0;
      endFrameAndDrain(DEPTH + 2);
      checkOutput("final_EMPTY", EMPTY, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
